// File: rtl/alu_pkg.sv
// Shared types for the execute stage: operation encoding, status bit
// positions and the result record held in the main and skid registers.
// No ports.
package alu_pkg;

   // Datapath width of the stored result record; alu_stage W must match.
   localparam int ALU_W = 16;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_SUB  = 2'b01,
      ALU_AND  = 2'b10,
      ALU_NOTB = 2'b11
   } aluop_t;

   localparam int STAT_Z = 0;
   localparam int STAT_N = 1;
   localparam int STAT_V = 2;

   typedef struct packed {
      logic [ALU_W-1:0] data;
      logic             z;
      logic             n;
      logic             v;
   } result_t;

   function automatic logic [2:0] pack_status(input logic z, input logic n, input logic v);
      logic [2:0] s;
      s         = 3'b000;
      s[STAT_Z] = z;
      s[STAT_N] = n;
      s[STAT_V] = v;
      return s;
   endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/result bus of the execute stage.
// master : upstream operand source plus downstream result consumer (drives
//          in_valid, ain, bin, aluop, load_status, out_ready)
// slave  : the alu_stage itself (drives in_ready, out_valid, out_data, status)
interface alu_if #(
   parameter int W = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] ain;
   logic [W-1:0] bin;
   logic [1:0]   aluop;
   logic         load_status;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [2:0]   status;

   modport master (
      output in_valid, ain, bin, aluop, load_status, out_ready,
      input  in_ready, out_valid, out_data, status
   );

   modport slave (
      input  in_valid, ain, bin, aluop, load_status, out_ready,
      output in_ready, out_valid, out_data, status
   );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: {ain, bin, aluop} -> {r, z, n, v}.
// Ports:
//   ain_i, bin_i : operands (W bits)
//   aluop_i      : ADD / SUB / AND / NOT B
//   r_o          : result, mod 2^W
//   z_o, n_o, v_o: zero, negative, signed overflow flags of r_o
module alu_core
   import alu_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0] ain_i,
   input  logic [W-1:0] bin_i,
   input  aluop_t       aluop_i,
   output logic [W-1:0] r_o,
   output logic         z_o,
   output logic         n_o,
   output logic         v_o
);

   always_comb begin
      r_o = '0;
      v_o = 1'b0;
      case (aluop_i)
         ALU_ADD: begin
            r_o = ain_i + bin_i;
            v_o = (ain_i[W-1] == bin_i[W-1]) && (r_o[W-1] != ain_i[W-1]);
         end
         ALU_SUB: begin
            r_o = ain_i - bin_i;
            v_o = (ain_i[W-1] != bin_i[W-1]) && (r_o[W-1] != ain_i[W-1]);
         end
         ALU_AND: r_o = ain_i & bin_i;
         default: r_o = ~bin_i;
      endcase
      z_o = (r_o == '0);
      n_o = r_o[W-1];
   end

endmodule

// File: rtl/alu_stage.sv
// Execute stage: ALU result registered behind valid/ready flow control,
// with a 2-entry (main + skid) buffer so in_ready is a flop output, and the
// architectural status register (Z, N, V).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_if slave modport (operands in, result and status out)
//
// Buffer occupancy:
//   state            | meaning
//   empty            | out_valid=0, skid_valid=0; in_ready=1
//   main             | out_valid=1, skid_valid=0; result presented, in_ready=1
//   main+skid (full) | out_valid=1, skid_valid=1; in_ready=0 until next fire
module alu_stage
   import alu_pkg::*;
#(
   parameter int W = ALU_W
) (
   input  logic  clk,
   input  logic  rst_n,
   alu_if.slave  bus
);

   logic [W-1:0] core_r;
   logic         core_z;
   logic         core_n;
   logic         core_v;
   result_t      res;

   result_t      main_q, main_d;
   result_t      skid_q, skid_d;
   logic         out_valid_q, out_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic [2:0]   status_q, status_d;

   logic         accept;
   logic         fire;

   alu_core #(.W(W)) u_core (
      .ain_i   (bus.ain),
      .bin_i   (bus.bin),
      .aluop_i (aluop_t'(bus.aluop)),
      .r_o     (core_r),
      .z_o     (core_z),
      .n_o     (core_n),
      .v_o     (core_v)
   );

   always_comb begin
      res      = '0;
      res.data = core_r;
      res.z    = core_z;
      res.n    = core_n;
      res.v    = core_v;
   end

   // in_ready depends only on the skid flop, never on out_ready.
   assign accept = bus.in_valid & ~skid_valid_q;
   assign fire   = out_valid_q & bus.out_ready;

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      status_d     = status_q;

      if (fire && skid_valid_q) begin
         main_d       = skid_q;
         skid_valid_d = 1'b0;
      end else if (fire && accept) begin
         main_d = res;
      end else if (fire) begin
         out_valid_d = 1'b0;
      end else if (!out_valid_q && accept) begin
         main_d      = res;
         out_valid_d = 1'b1;
      end else if (out_valid_q && accept) begin
         skid_d       = res;
         skid_valid_d = 1'b1;
      end

      // Status follows accepts, not fires, so stalls downstream never delay it.
      if (accept && bus.load_status) begin
         status_d = pack_status(core_z, core_n, core_v);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q       <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         status_q     <= 3'b000;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         status_q     <= status_d;
      end
   end

   assign bus.in_ready  = ~skid_valid_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = main_q.data;
   assign bus.status    = status_q;

endmodule

// File: tb/tb_alu_stage.sv
module tb_alu_stage;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_if #(.W(16)) bus ();

   alu_stage #(.W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent reference: overflow from signed integer range.
   function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return ~b;
      endcase
   endfunction

   function automatic logic [2:0] ref_stat(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
      int          sa, sb, s;
      logic        v;
      logic [15:0] r;
      sa = $signed(a);
      sb = $signed(b);
      r  = ref_r(a, b, op);
      v  = 1'b0;
      if (op == 2'b00) begin
         s = sa + sb;
         v = (s > 32767) || (s < -32768);
      end else if (op == 2'b01) begin
         s = sa - sb;
         v = (s > 32767) || (s < -32768);
      end
      return {v, r[15], (r == 16'h0000)};
   endfunction

   task automatic drive(input logic vld, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input logic ls);
      bus.in_valid    = vld;
      bus.ain         = a;
      bus.bin         = b;
      bus.aluop       = op;
      bus.load_status = ls;
   endtask

   task automatic test_reset;
      bus.out_ready = 1'b1;
      drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.status !== 3'b000 || bus.out_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset: valid=%b ready=%b status=%b data=%h, need 0 1 000 0000",
                  bus.out_valid, bus.in_ready, bus.status, bus.out_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_add_overflow;
      bus.out_ready = 1'b1;
      drive(1'b1, 16'h7FFF, 16'h0001, 2'b00, 1'b1);
      @(negedge clk);
      drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h8000) begin
         errors++;
         $display("FAIL add_ovf data: valid=%b data=%h, need 1 8000", bus.out_valid, bus.out_data);
      end
      checks++;
      if (bus.status !== 3'b110) begin
         errors++;
         $display("FAIL add_ovf status: got %b need 110", bus.status);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_ovf drain: out_valid=%b need 0", bus.out_valid);
      end
   endtask

   task automatic test_sub_zero;
      bus.out_ready = 1'b1;
      drive(1'b1, 16'h1234, 16'h1234, 2'b01, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0000 || bus.status !== 3'b001) begin
         errors++;
         $display("FAIL sub_zero: valid=%b data=%h status=%b, need 1 0000 001",
                  bus.out_valid, bus.out_data, bus.status);
      end
      drive(1'b1, 16'hFFFF, 16'h0000, 2'b10, 1'b0);
      @(negedge clk);
      drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0000 || bus.status !== 3'b001) begin
         errors++;
         $display("FAIL status_hold: valid=%b data=%h status=%b, need 1 0000 001",
                  bus.out_valid, bus.out_data, bus.status);
      end
      @(negedge clk);
   endtask

   task automatic test_sub_overflow;
      bus.out_ready = 1'b1;
      drive(1'b1, 16'h8000, 16'h0001, 2'b01, 1'b1);
      @(negedge clk);
      drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h7FFF || bus.status !== 3'b100) begin
         errors++;
         $display("FAIL sub_ovf: valid=%b data=%h status=%b, need 1 7fff 100",
                  bus.out_valid, bus.out_data, bus.status);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      bus.out_ready = 1'b0;
      drive(1'b1, 16'h0000, 16'h00FF, 2'b11, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hFF00 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_first: valid=%b data=%h ready=%b, need 1 ff00 1",
                  bus.out_valid, bus.out_data, bus.in_ready);
      end
      drive(1'b1, 16'h0003, 16'h0004, 2'b00, 1'b0);
      @(negedge clk);
      drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_data !== 16'hFF00) begin
         errors++;
         $display("FAIL bp_full: ready=%b data=%h, need 0 ff00", bus.in_ready, bus.out_data);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hFF00 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_hold: valid=%b data=%h ready=%b, need 1 ff00 0",
                  bus.out_valid, bus.out_data, bus.in_ready);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0007 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_second: valid=%b data=%h ready=%b, need 1 0007 1",
                  bus.out_valid, bus.out_data, bus.in_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.status !== 3'b100) begin
         errors++;
         $display("FAIL bp_drain: valid=%b status=%b, need 0 100", bus.out_valid, bus.status);
      end
   endtask

   task automatic test_reset_mid;
      bus.out_ready = 1'b0;
      drive(1'b1, 16'h8000, 16'h8000, 2'b10, 1'b1);
      @(negedge clk);
      drive(1'b1, 16'h0001, 16'h0001, 2'b00, 1'b0);
      @(negedge clk);
      drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.status !== 3'b010) begin
         errors++;
         $display("FAIL rstmid_fill: ready=%b status=%b, need 0 010", bus.in_ready, bus.status);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.status !== 3'b000) begin
         errors++;
         $display("FAIL rstmid_async: valid=%b ready=%b status=%b, need 0 1 000",
                  bus.out_valid, bus.in_ready, bus.status);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_release cyc %0d: out_valid=%b need 0", i, bus.out_valid);
         end
      end
   endtask

   task automatic test_streaming;
      logic [15:0] q[$];
      logic [15:0] a, b;
      logic [1:0]  op;
      logic        ls;
      logic [2:0]  exp_status;
      int          issued, cycles;
      exp_status = 3'b000;
      issued     = 0;
      cycles     = 0;
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = 2'($urandom_range(0, 3));
      ls = 1'($urandom_range(0, 1));
      while ((issued < 100 || q.size() != 0) && cycles < 3000) begin
         @(negedge clk);
         cycles++;
         checks++;
         if (bus.status !== exp_status) begin
            errors++;
            $display("FAIL stream_status: got %b need %b", bus.status, exp_status);
         end
         if (q.size() != 0) begin
            checks++;
            if (bus.out_valid !== 1'b1) begin
               errors++;
               $display("FAIL stream_pending: out_valid=%b need 1 with %0d queued", bus.out_valid, q.size());
            end
         end
         drive(issued < 100, a, b, op, ls);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (bus.out_valid === 1'b1 && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL stream_extra: data=%h need no output", bus.out_data);
            end else begin
               if (bus.out_data !== q[0]) begin
                  errors++;
                  $display("FAIL stream_data: got %h need %h", bus.out_data, q[0]);
               end
               void'(q.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready === 1'b1) begin
            q.push_back(ref_r(a, b, op));
            if (ls) exp_status = ref_stat(a, b, op);
            issued++;
            a  = 16'($urandom);
            b  = 16'($urandom);
            op = 2'($urandom_range(0, 3));
            ls = 1'($urandom_range(0, 1));
         end
      end
      drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
      checks++;
      if (cycles >= 3000) begin
         errors++;
         $display("FAIL stream_timeout: issued=%0d queued=%0d need 100 0", issued, q.size());
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      test_reset;
      test_add_overflow;
      test_sub_zero;
      test_sub_overflow;
      test_back_to_back;
      test_reset_mid;
      test_streaming;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_stage.md
Name: alu_stage

Overview:
Execute stage directly downstream of the datapath shifter. It takes operand A and the shifted operand B, runs one of four ALU operations, and registers the result with valid/ready flow control. It also keeps the architectural status register (Z, N, V). A 2-entry skid buffer keeps in_ready registered, so back-pressure from the writeback/C-register consumer never forms a combinational path into the shifter or operand registers.

Parameters:
W, 16, datapath width in bits (matches the shifter output width)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream holds a valid operand pair plus op
in_ready  output  1  stage can accept; registered (= ~skid_valid)
ain  input  W  operand A (register A output)
bin  input  W  operand B (shifter sout)
aluop  input  2  00 ADD, 01 SUB, 10 AND, 11 NOT B
load_status  input  1  this transaction updates the status register
out_valid  output  1  out_data holds a result
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  W  registered ALU result
status  output  3  [0]=Z, [1]=N, [2]=V; registered

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- While rst_n=0, asynchronously: out_valid=0, out_data=0, status=3'b000, skid_valid=0 (so in_ready=1). Any in-flight result is dropped. Release takes effect at the first clk edge with rst_n=1.
- Accept condition: in_valid & in_ready at a rising edge. Fire condition: out_valid & out_ready at a rising edge.
- Result is computed combinationally at the input:
  - ADD = ain+bin mod 2^W
  - SUB = ain-bin mod 2^W
  - AND = ain&bin
  - NOT = ~bin (ain ignored)
- Flags for result r:
  - Z = (r==0)
  - N = r[W-1]
  - V for ADD: ain[W-1]==bin[W-1] && r[W-1]!=ain[W-1]
  - V for SUB: ain[W-1]!=bin[W-1] && r[W-1]!=ain[W-1]
  - V for AND/NOT: 0
- Latency: one cycle. A result accepted at edge k is visible on out_data with out_valid=1 after edge k. Throughput is 1/cycle while out_ready=1.
- Main register update on each edge, first matching rule wins:
  - fire & skid_valid -> main <= skid, skid_valid <= 0 (an accept in the same edge is impossible, since in_ready=0)
  - fire & accept -> main <= new result
  - fire & !accept -> out_valid <= 0
  - !out_valid & accept -> main <= new result, out_valid <= 1
  - out_valid & !fire & accept -> skid <= new result, skid_valid <= 1
- Holding rules:
  - out_data and out_valid stay stable while out_valid & !out_ready.
  - Results never reorder, drop or duplicate.
- Status register:
  - Updates at the accept edge, from that transaction's flags, only when load_status=1.
  - Otherwise it holds.
  - It is independent of downstream stalls; a skidded result has already updated status.
- Full condition: main and skid both occupied. in_ready=0 until the next fire.
- Upstream must hold in_valid and its operands stable until accepted. The stage does not check this.

Decomposition:
- Shared package alu_pkg holds:
  - enum aluop_t {ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_NOTB=2'b11}
  - localparams STAT_Z=0, STAT_N=1, STAT_V=2
  - result struct {data[W], z, n, v} used by both the main and skid registers
- One sub-module, alu_core: a purely combinational {ain, bin, aluop} -> {r, z, n, v}, reused by the datapath's top-level checker.
- Skid/main control stays in alu_stage.

Test Plan:
- Reset mid-stream:
  - Stimulus: fill main and skid, then assert rst_n=0 between edges.
  - Required: out_valid=0, in_ready=1 and status=000 immediately; no result is emitted after release.
- ADD overflow:
  - Stimulus: ain=16'h7FFF, bin=16'h0001, ADD, load_status=1.
  - Required: out_data=16'h8000 one cycle later; status Z=0, N=1, V=1.
- SUB to zero, then status hold:
  - Stimulus: ain=bin=16'h1234, SUB, load_status=1.
  - Required: out_data=0, Z=1, N=0, V=0.
  - Stimulus: next, AND 16'hFFFF & 16'h0000 with load_status=0.
  - Required: out_data=0 and status unchanged.
- Back-pressure:
  - Stimulus: out_ready=0 while issuing NOT bin=16'h00FF then ADD 3+4.
  - Required: out_data holds 16'hFF00 and in_ready=0 after the second accept.
  - Stimulus: raise out_ready.
  - Required: 16'hFF00 then 16'h0007 on consecutive cycles, and in_ready returns to 1.
- Streaming:
  - Stimulus: 100 random back-to-back ops with random out_ready.
  - Required: output sequence equals the alu_core reference model in order; no gaps while out_ready=1.
- SUB overflow:
  - Stimulus: ain=16'h8000, bin=16'h0001.
  - Required: out_data=16'h7FFF, V=1, N=0.
